// File: rtl/cpm_pkg.sv
// Shared types for the CPM top-K datapath: entry value/info/index/count widths and the
// serializer FSM states.
package cpm_pkg;

    localparam int CPM_DATA_DW = 8;
    localparam int CPM_INFO_DW = 8;
    localparam int CPM_SORT_DW = 32;
    localparam int CPM_SORT_AW = $clog2(CPM_SORT_DW);

    typedef logic [CPM_DATA_DW-1:0] topk_dat_t;
    typedef logic [CPM_INFO_DW-1:0] topk_inf_t;
    typedef logic [CPM_SORT_AW-1:0] topk_idx_t;
    typedef logic [CPM_SORT_AW:0]   topk_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } topk_state_e;

    function automatic topk_cnt_t topk_min(input topk_cnt_t a, input topk_cnt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cpm_topk_lead_nz.sv
// Combinational count of leading nonzero entries in a sorted top-K array; the first zero
// value ends the run, since zero-filled slots only ever trail the valid ones.
module cpm_topk_lead_nz
    import cpm_pkg::*;
#(
    parameter int DATA_DW = CPM_DATA_DW,
    parameter int SORT_DW = CPM_SORT_DW
) (
    input  logic [SORT_DW*DATA_DW-1:0] dat_i,
    output topk_cnt_t                  cnt_o
);

    logic stop;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        cnt_o = '0;
        stop  = 1'b0;
        for (int i = 0; i < SORT_DW; i++) begin
            if (dat_i[i*DATA_DW +: DATA_DW] == '0) begin
                stop = 1'b1;
            end else if (!stop) begin
                cnt_o = cnt_o + topk_cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/cpm_topk_serializer.sv
// Snapshots the sorter's top-K array on the rise of its result-valid and streams the first
// CFG_TOPK_NUM entries, highest first, as valid/ready/last beats. Option: CPM_TOPK_SKIP_ZERO_EN.
module cpm_topk_serializer
    import cpm_pkg::*;
#(
    parameter int DATA_DW = CPM_DATA_DW,
    parameter int INFO_DW = CPM_INFO_DW,
    parameter int SORT_DW = CPM_SORT_DW,
    parameter int SORT_AW = $clog2(SORT_DW)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       TOPK_DAT_VLD,
    input  logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT,
    input  logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF,
    input  logic [SORT_AW:0]           CFG_TOPK_NUM,
    output logic                       OUT_DAT_VLD,
    input  logic                       OUT_DAT_RDY,
    output logic                       OUT_DAT_LST,
    output logic [DATA_DW-1:0]         OUT_DAT_DAT,
    output logic [INFO_DW-1:0]         OUT_DAT_INF,
    output logic [SORT_AW-1:0]         OUT_DAT_IDX,
    output logic                       BUSY,
    output logic                       DONE
);

    topk_state_e state_q, state_d;
    logic        topk_vld_q;
    logic        start;
    logic        capture;
    topk_cnt_t   cfg_clip, cnt_start, cnt_q, cnt_d;
    topk_dat_t   snap_dat_q [SORT_DW];
    topk_inf_t   snap_inf_q [SORT_DW];
    logic        out_vld_q, out_vld_d;
    logic        out_lst_q, out_lst_d;
    logic        done_q, done_d;
    topk_dat_t   out_dat_q, out_dat_d;
    topk_inf_t   out_inf_q, out_inf_d;
    topk_idx_t   out_idx_q, out_idx_d, idx_nxt;

    assign start    = TOPK_DAT_VLD & ~topk_vld_q;
    assign cfg_clip = (CFG_TOPK_NUM > topk_cnt_t'(SORT_DW)) ? topk_cnt_t'(SORT_DW) : CFG_TOPK_NUM;
    assign idx_nxt  = out_idx_q + topk_idx_t'(1);

`ifdef CPM_TOPK_SKIP_ZERO_EN
    topk_cnt_t lead_cnt;

    cpm_topk_lead_nz #(
        .DATA_DW (DATA_DW),
        .SORT_DW (SORT_DW)
    ) u_lead_nz (
        .dat_i (TOPK_DAT_DAT),
        .cnt_o (lead_cnt)
    );

    assign cnt_start = topk_min(cfg_clip, lead_cnt);
`else
    assign cnt_start = cfg_clip;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_lst_d = out_lst_q;
        out_dat_d = out_dat_q;
        out_inf_d = out_inf_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            out_vld_d = 1'b0;
            out_lst_d = 1'b0;
            out_dat_d = '0;
            out_inf_d = '0;
            out_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        capture   = 1'b1;
                        cnt_d     = cnt_start;
                        out_idx_d = '0;
                        if (cnt_start == '0) begin
                            done_d = 1'b1;
                        end else begin
                            // Beat 0 comes straight from the inputs so it is valid one cycle after start.
                            state_d   = SEND;
                            out_vld_d = 1'b1;
                            out_dat_d = TOPK_DAT_DAT[DATA_DW-1:0];
                            out_inf_d = TOPK_DAT_INF[INFO_DW-1:0];
                            out_lst_d = (cnt_start == topk_cnt_t'(1));
                        end
                    end
                end
                SEND: begin
                    if (OUT_DAT_RDY) begin
                        if (out_lst_q) begin
                            state_d   = IDLE;
                            out_vld_d = 1'b0;
                            out_lst_d = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            out_idx_d = idx_nxt;
                            out_dat_d = snap_dat_q[idx_nxt];
                            out_inf_d = snap_inf_q[idx_nxt];
                            out_lst_d = ({1'b0, idx_nxt} == (cnt_q - topk_cnt_t'(1)));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            topk_vld_q <= 1'b0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_lst_q  <= 1'b0;
            out_dat_q  <= '0;
            out_inf_q  <= '0;
            out_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            topk_vld_q <= clear ? 1'b0 : TOPK_DAT_VLD;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_lst_q  <= out_lst_d;
            out_dat_q  <= out_dat_d;
            out_inf_q  <= out_inf_d;
            out_idx_q  <= out_idx_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the snapshot is a register bank, not a RAM, so it can and must be reset/cleared to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SORT_DW; i++) begin
                snap_dat_q[i] <= '0;
                snap_inf_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < SORT_DW; i++) begin
                snap_dat_q[i] <= '0;
                snap_inf_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < SORT_DW; i++) begin
                snap_dat_q[i] <= TOPK_DAT_DAT[i*DATA_DW +: DATA_DW];
                snap_inf_q[i] <= TOPK_DAT_INF[i*INFO_DW +: INFO_DW];
            end
        end
    end

    assign OUT_DAT_VLD = out_vld_q;
    assign OUT_DAT_LST = out_lst_q;
    assign OUT_DAT_DAT = out_dat_q;
    assign OUT_DAT_INF = out_inf_q;
    assign OUT_DAT_IDX = out_idx_q;
    assign BUSY        = (state_q == SEND);
    assign DONE        = done_q;

endmodule

// File: tb/tb_cpm_topk_serializer.sv
// Directed bench for cpm_topk_serializer: basic stream, backpressure, clip, empty, clear,
// skip-zero (either build of CPM_TOPK_SKIP_ZERO_EN) and level-hold of the sorter valid.
module tb_cpm_topk_serializer;

    localparam int DATA_DW = 8;
    localparam int INFO_DW = 8;
    localparam int SORT_DW = 32;
    localparam int SORT_AW = 5;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       clear;
    logic                       topk_vld;
    logic [SORT_DW*DATA_DW-1:0] topk_dat;
    logic [SORT_DW*INFO_DW-1:0] topk_inf;
    logic [SORT_AW:0]           cfg_num;
    logic                       out_vld;
    logic                       out_rdy;
    logic                       out_lst;
    logic [DATA_DW-1:0]         out_dat;
    logic [INFO_DW-1:0]         out_inf;
    logic [SORT_AW-1:0]         out_idx;
    logic                       busy;
    logic                       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdat [SORT_DW];
    logic [7:0] minf [SORT_DW];

    cpm_topk_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .TOPK_DAT_VLD (topk_vld),
        .TOPK_DAT_DAT (topk_dat),
        .TOPK_DAT_INF (topk_inf),
        .CFG_TOPK_NUM (cfg_num),
        .OUT_DAT_VLD  (out_vld),
        .OUT_DAT_RDY  (out_rdy),
        .OUT_DAT_LST  (out_lst),
        .OUT_DAT_DAT  (out_dat),
        .OUT_DAT_INF  (out_inf),
        .OUT_DAT_IDX  (out_idx),
        .BUSY         (busy),
        .DONE         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: 31..0 descending; kind 1: {9,7,5,0,...}; kind 2: 200..169 descending.
    task automatic load_array(input int kind);
        for (int i = 0; i < SORT_DW; i++) begin
            case (kind)
                0:       mdat[i] = 8'(31 - i);
                1:       mdat[i] = (i < 3) ? 8'(9 - 2 * i) : 8'd0;
                default: mdat[i] = 8'(200 - i);
            endcase
            minf[i] = 8'((i * 3 + 1) ^ (kind * 16));
            topk_dat[i*DATA_DW +: DATA_DW] = mdat[i];
            topk_inf[i*INFO_DW +: INFO_DW] = minf[i];
        end
    endtask

    // Caller has raised topk_vld; this takes the start edge and follows the stream to DONE.
    task automatic run_stream(input string tag, input int n_exp, input bit toggle);
        int  got;
        bit  r;
        got = 0;
        out_rdy = 1'b1;
        step();
        for (int cyc = 0; cyc < 400 && got < n_exp; cyc++) begin
            if (out_vld !== 1'b1) begin
                check({tag, "_vld"}, 32'(out_vld), 32'd1);
                break;
            end
            check({tag, "_dat"}, 32'(out_dat), 32'(mdat[got]));
            check({tag, "_inf"}, 32'(out_inf), 32'(minf[got]));
            check({tag, "_idx"}, 32'(out_idx), 32'(got));
            check({tag, "_lst"}, 32'(out_lst), 32'(got == n_exp - 1));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            r = toggle ? cyc[0] : 1'b1;
            out_rdy = r;
            step();
            if (r) got++;
        end
        check({tag, "_beats"}, 32'(got), 32'(n_exp));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_vld_drop"}, 32'(out_vld), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        out_rdy = 1'b1;
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen;
        rst_n    = 1'b0;
        clear    = 1'b0;
        topk_vld = 1'b0;
        out_rdy  = 1'b1;
        cfg_num  = '0;
        load_array(0);
        #1;
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dat", 32'(out_dat), 32'd0);
        #12 rst_n = 1'b1;
        step();

        // Basic: 4 beats 31,30,29,28 with RDY held high.
        cfg_num  = 6'd4;
        topk_vld = 1'b1;
        run_stream("basic", 4, 1'b0);

        // Level hold: valid stays high, no second stream may start.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            seen |= out_vld | done | busy;
        end
        check("level_hold_quiet", 32'(seen), 32'd0);
        topk_vld = 1'b0;
        step();
        topk_vld = 1'b1;
        run_stream("level_restart", 4, 1'b0);
        topk_vld = 1'b0;
        step();

        // Backpressure: RDY toggles 0/1 every cycle.
        cfg_num  = 6'd3;
        topk_vld = 1'b1;
        run_stream("bp", 3, 1'b1);
        topk_vld = 1'b0;
        step();

        // Clip: 40 is clipped to 32 beats.
        cfg_num  = 6'd40;
        topk_vld = 1'b1;
        run_stream("clip", 32, 1'b0);
        topk_vld = 1'b0;
        step();

        // Empty: no beats, DONE pulse one cycle after start.
        cfg_num  = 6'd0;
        topk_vld = 1'b1;
        step();
        check("empty_done", 32'(done), 32'd1);
        check("empty_vld", 32'(out_vld), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        step();
        check("empty_done_pulse", 32'(done), 32'd0);
        check("empty_vld2", 32'(out_vld), 32'd0);
        topk_vld = 1'b0;
        step();

        // Clear after 2 handshakes of an 8-beat stream.
        cfg_num  = 6'd8;
        topk_vld = 1'b1;
        step();
        check("clr_b0_dat", 32'(out_dat), 32'd31);
        step();
        check("clr_b1_dat", 32'(out_dat), 32'd30);
        step();
        check("clr_b2_idx", 32'(out_idx), 32'd2);
        clear    = 1'b1;
        topk_vld = 1'b0;
        step();
        clear = 1'b0;
        check("clr_vld", 32'(out_vld), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_idx", 32'(out_idx), 32'd0);
        step();
        check("clr_no_done", 32'(done), 32'd0);
        check("clr_still_idle", 32'(out_vld), 32'd0);
        load_array(2);
        cfg_num  = 6'd2;
        topk_vld = 1'b1;
        run_stream("clr_restart", 2, 1'b0);
        topk_vld = 1'b0;
        step();

        // Skip-zero array {9,7,5,0,...} with CFG=6.
        load_array(1);
        cfg_num  = 6'd6;
        topk_vld = 1'b1;
`ifdef CPM_TOPK_SKIP_ZERO_EN
        run_stream("skipzero", 3, 1'b0);
`else
        run_stream("skipzero", 6, 1'b0);
`endif
        topk_vld = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
